bit_vector_encoder: RTL and testbench

- Streaming encoder: accepts an N-bit request vector, such as one row of live cells from the game-of-life grid.
- Emits the binary index of every set bit, one index per handshake, lowest index first.
- Sits between the grid/decoder datapath and downstream consumers that need cell addresses instead of one-hot or bitmap form.
- Valid/ready on both sides; one vector in flight at a time.

---
 rtl/bit_vector_encoder.sv | 77 +++++++
 tb/tb_bit_vector_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_vector_encoder.sv
// Streaming bitmap-to-index encoder: captures one N-bit vector, then emits each set bit's index, lowest first, one per beat.
// First beat is valid the cycle after capture. out_ready low holds the beat, and in_ready stays low until the last beat retires.
module bit_vector_encoder #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_index,
  output logic         out_last,
  output logic         out_empty
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [N-1:0] ONE = N'(1);

  state_t       state;
  logic [N-1:0] pending;
  logic         zero_flag;
  logic [W-1:0] low_idx;
  logic         single_bit;

  // Priority encoder: the loop runs downward so the lowest set bit is assigned last and wins.
  always_comb begin
    low_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending[i]) low_idx = W'(i);
    end
  end

  assign single_bit = (pending != '0) && ((pending & (pending - ONE)) == '0);

  // All outputs are forced low while rst is high, so reset takes effect in the same cycle.
  assign in_ready  = !rst && (state == S_IDLE);
  assign out_valid = !rst && (state == S_BUSY);
  assign out_index = rst ? '0 : low_idx;
  assign out_last  = out_valid && (zero_flag || single_bit);
  assign out_empty = out_valid && zero_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pending   <= '0;
      zero_flag <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            pending   <= in_data;
            zero_flag <= (in_data == '0);
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (out_ready) begin
            if (zero_flag || single_bit) begin
              pending   <= '0;
              zero_flag <= 1'b0;
              state     <= S_IDLE;
            end else begin
              // Subtract-and-mask clears the lowest set bit, which is the one at low_idx.
              pending <= pending & (pending - ONE);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bit_vector_encoder.sv
// Self-checking bench for bit_vector_encoder (N=16): directed scenarios plus randomized vectors against a queue model.
module tb_bit_vector_encoder;
  localparam int N = 16;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_index;
  logic         out_last;
  logic         out_empty;

  int errors = 0;
  int checks = 0;

  bit_vector_encoder #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_last(out_last), .out_empty(out_empty)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends one vector and checks every beat. mode 0: out_ready always high,
  // mode 1: ready pattern 1,0,0,1,1,0,1 repeating, mode 2: random ready.
  task automatic send_and_check(input logic [N-1:0] vec, input int mode, input string name);
    int exp_q[$];
    int total, beats, cyc;
    logic is_zero, stalled;
    logic [W-1:0] p_idx;
    logic p_last, p_empty;
    logic [W-1:0] e_idx;
    logic e_last;
    bit pat[7] = '{1, 0, 0, 1, 1, 0, 1};

    for (int i = 0; i < N; i++) if (vec[i]) exp_q.push_back(i);
    is_zero = (vec == '0);
    total = is_zero ? 1 : exp_q.size();

    cyc = 0;
    while (!in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s wait_in_ready: in_ready=%b required 1", name, in_ready);
      return;
    end

    in_valid = 1'b1;
    in_data  = vec;
    tick();
    in_valid = 1'b0;

    beats = 0; stalled = 1'b0; cyc = 0;
    p_idx = '0; p_last = 1'b0; p_empty = 1'b0;
    while (beats < total && cyc < 200) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = pat[cyc % 7];
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      // Producer noise while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      in_data  = N'($urandom);

      e_idx  = is_zero ? '0 : W'(exp_q[beats]);
      e_last = (beats == total - 1);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s busy_flags beat %0d: out_valid=%b in_ready=%b required 1/0",
                 name, beats, out_valid, in_ready);
      end
      checks++;
      if (out_index !== e_idx || out_last !== e_last || out_empty !== is_zero) begin
        errors++;
        $display("FAIL %s beat %0d: index=%0d last=%b empty=%b required index=%0d last=%b empty=%b",
                 name, beats, out_index, out_last, out_empty, e_idx, e_last, is_zero);
      end
      if (stalled) begin
        checks++;
        if (out_index !== p_idx || out_last !== p_last || out_empty !== p_empty) begin
          errors++;
          $display("FAIL %s stall_hold beat %0d: index=%0d last=%b empty=%b required index=%0d last=%b empty=%b",
                   name, beats, out_index, out_last, out_empty, p_idx, p_last, p_empty);
        end
      end
      p_idx = out_index; p_last = out_last; p_empty = out_empty;
      stalled = !out_ready;
      if (out_ready) beats++;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;

    checks++;
    if (beats != total) begin
      errors++;
      $display("FAIL %s beat_count: got %0d beats required %0d", name, beats, total);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != total) begin
        errors++;
        $display("FAIL %s busy_cycles: %0d required %0d", name, cyc, total);
      end
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s return_idle: in_ready=%b out_valid=%b required 1/0", name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h1234;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_index !== '0 ||
          out_last !== 1'b0 || out_empty !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: in_ready=%b out_valid=%b index=%0d last=%b empty=%b required all 0",
                 i, in_ready, out_valid, out_index, out_last, out_empty);
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_beat: out_valid=%b required 0", out_valid);
    end
  endtask

  task automatic test_single_bit();
    send_and_check(16'h0100, 0, "single_bit");
  endtask

  task automatic test_stalls();
    send_and_check(16'h8421, 1, "multi_stall");
  endtask

  task automatic test_zero();
    send_and_check(16'h0000, 0, "zero_vec");
    send_and_check(16'h0000, 1, "zero_vec_stall");
  endtask

  task automatic test_back_to_back();
    send_and_check(16'hFFFF, 0, "all_ones");
    send_and_check(16'h0003, 0, "b2b_0003");
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1;
    in_data  = 16'h00F0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b1 || out_index !== 4'd4) begin
      errors++;
      $display("FAIL mid_reset beat4: valid=%b index=%0d required 1/4", out_valid, out_index);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_index !== 4'd5) begin
      errors++;
      $display("FAIL mid_reset beat5: valid=%b index=%0d required 1/5", out_valid, out_index);
    end
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_index !== '0) begin
      errors++;
      $display("FAIL mid_reset during: valid=%b in_ready=%b index=%0d required 0/0/0",
               out_valid, in_ready, out_index);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset after: valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset leftover: out_valid=%b required 0", out_valid);
    end
    send_and_check(16'h0002, 0, "post_reset_0002");
  endtask

  task automatic test_random();
    logic [N-1:0] v;
    for (int t = 0; t < 25; t++) begin
      v = N'($urandom);
      if (t % 3 == 1) v = v & N'($urandom) & N'($urandom);
      if (t % 8 == 5) v = '0;
      send_and_check(v, 2, "random");
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_stalls();
    test_zero();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
